// File: rtl/pipe_sequencer.sv
// Pipeline run/pause/single-step sequencer: drives the global exec enable,
// branch flush and saturating cycle/instruction counters for a 5-stage core.

package pipe_sequencer_pkg;
  // Shared opcode map, bits [15:11] of every instruction word.
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_BZ   = 5'h10;
  localparam logic [4:0] OP_BNZ  = 5'h11;
  localparam logic [4:0] OP_BN   = 5'h12;
  localparam logic [4:0] OP_BNN  = 5'h13;
  localparam logic [4:0] OP_BC   = 5'h14;
  localparam logic [4:0] OP_BNC  = 5'h15;
  localparam logic [4:0] OP_JMPR = 5'h16;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSE  = 2'b10,
    S_HALTED = 2'b11
  } seq_state_t;
endpackage

module pipe_sequencer
  import pipe_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  logic        step_mode,
  input  logic        step,
  input  logic [15:0] mem_ir,
  input  logic [15:0] wb_ir,
  input  logic        zf,
  input  logic        nf,
  input  logic        cf,
  output logic        state,
  output logic        flush,
  output logic        halted,
  output logic [1:0]  fsm_state,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
);

  seq_state_t cur_state, nxt_state;
  logic       step_d;
  logic       step_fire;
  logic [4:0] mem_op;
  logic [4:0] wb_op;
  logic       wb_halt;
  logic       taken;

  assign mem_op  = mem_ir[15:11];
  assign wb_op   = wb_ir[15:11];
  assign wb_halt = (wb_op == OP_HALT);

  // Operand fields are not needed by the sequencer.
  logic unused_operands;
  assign unused_operands = ^{mem_ir[10:0], wb_ir[10:0]};

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= S_IDLE;
      step_d      <= 1'b0;
      step_fire   <= 1'b0;
      cycle_count <= 16'h0000;
      instr_count <= 16'h0000;
    end else begin
      cur_state <= nxt_state;
      step_d    <= step;
      step_fire <= (cur_state == S_PAUSE) && step_mode && step && !step_d;
      if (state && (cycle_count != 16'hFFFF))
        cycle_count <= cycle_count + 16'd1;
      if (state && (wb_op != OP_NOP) && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 16'd1;
    end
  end

  // NOTE: defaults come first in every always_comb so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = step_mode ? S_PAUSE : S_RUN;
      end
      S_RUN: begin
        if (wb_halt)                   nxt_state = S_HALTED;
        else if (!enable || step_mode) nxt_state = S_PAUSE;
      end
      S_PAUSE: begin
        // A single-stepped HALT retires during the step_fire cycle.
        if (step_fire && wb_halt)       nxt_state = S_HALTED;
        else if (enable && !step_mode)  nxt_state = S_RUN;
      end
      S_HALTED: nxt_state = S_HALTED;
      default:  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (mem_op)
      OP_BZ:   taken = zf;
      OP_BNZ:  taken = !zf;
      OP_BN:   taken = nf;
      OP_BNN:  taken = !nf;
      OP_BC:   taken = cf;
      OP_BNC:  taken = !cf;
      OP_JMPR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign state     = (cur_state == S_RUN) || step_fire;
  assign flush     = state && taken;
  assign halted    = (cur_state == S_HALTED);
  assign fsm_state = cur_state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: a cycle-level reference model checked every
// cycle, plus literal expectations for the reset, halt, step and saturation cases.

module tb_pipe_sequencer;
  import pipe_sequencer_pkg::*;

  localparam logic [4:0] OP_ALU = 5'h01;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALTED = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] mem_ir = 16'h0000;
  logic [15:0] wb_ir = 16'h0000;
  logic        zf = 1'b0, nf = 1'b0, cf = 1'b0;
  logic        state, flush, halted;
  logic [1:0]  fsm_state;
  logic [15:0] cycle_count, instr_count;

  pipe_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .step_mode(step_mode), .step(step), .mem_ir(mem_ir), .wb_ir(wb_ir),
    .zf(zf), .nf(nf), .cf(cf), .state(state), .flush(flush), .halted(halted),
    .fsm_state(fsm_state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ir(input logic [4:0] op);
    return {op, 11'h2A5};
  endfunction

  function automatic bit branch_taken(input logic [15:0] i, input logic z, input logic n, input logic c);
    logic [4:0] op;
    op = i[15:11];
    return (op == OP_BZ && z)  || (op == OP_BNZ && !z) ||
           (op == OP_BN && n)  || (op == OP_BNN && !n) ||
           (op == OP_BC && c)  || (op == OP_BNC && !c) || (op == OP_JMPR);
  endfunction

  // Reference model: mode, pending step pulse, previous step level, counters.
  int m_mode = M_IDLE;
  bit m_fire = 1'b0, m_prev = 1'b0, m_fire_n, m_live;
  int m_cyc = 0, m_ins = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_IDLE; m_fire = 1'b0; m_prev = 1'b0; m_cyc = 0; m_ins = 0;
    end else begin
      m_live = (m_mode == M_RUN) || m_fire;
      if (m_live) begin
        if (m_cyc < 65535) m_cyc++;
        if (wb_ir[15:11] != OP_NOP && m_ins < 65535) m_ins++;
      end
      m_fire_n = (m_mode == M_PAUSE) && step_mode && step && !m_prev;
      case (m_mode)
        M_IDLE:  if (start) m_mode = step_mode ? M_PAUSE : M_RUN;
        M_RUN:   if (wb_ir[15:11] == OP_HALT) m_mode = M_HALTED;
                 else if (!enable || step_mode) m_mode = M_PAUSE;
        M_PAUSE: if (m_fire && wb_ir[15:11] == OP_HALT) m_mode = M_HALTED;
                 else if (enable && !step_mode) m_mode = M_RUN;
        default: ;
      endcase
      m_fire = m_fire_n;
      m_prev = step;
    end
  end

  bit chk_en = 1'b0;
  bit c_live;
  always @(negedge clock) begin
    if (chk_en) begin
      c_live = (m_mode == M_RUN) || m_fire;
      check("state",       32'(state),       32'(c_live));
      check("flush",       32'(flush),       32'(c_live && branch_taken(mem_ir, zf, nf, cf)));
      check("halted",      32'(halted),      32'(m_mode == M_HALTED));
      check("fsm_state",   32'(fsm_state),   32'(m_mode));
      check("cycle_count", 32'(cycle_count), m_cyc);
      check("instr_count", 32'(instr_count), m_ins);
    end
  end

  bit win = 1'b0;
  int hi_cnt = 0;
  always @(negedge clock) if (win && state) hi_cnt++;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  typedef struct { logic [4:0] op; logic z, n, c; } br_t;
  br_t tab [10] = '{
    '{OP_BZ, 1'b1, 1'b0, 1'b0}, '{OP_BZ, 1'b0, 1'b1, 1'b1}, '{OP_BNZ, 1'b0, 1'b0, 1'b0},
    '{OP_BN, 1'b0, 1'b1, 1'b0}, '{OP_BNN, 1'b0, 1'b1, 1'b0}, '{OP_BC, 1'b0, 1'b0, 1'b1},
    '{OP_BNC, 1'b1, 1'b1, 1'b0}, '{OP_BNC, 1'b0, 1'b0, 1'b1}, '{OP_JMPR, 1'b0, 1'b0, 1'b0},
    '{OP_ALU, 1'b1, 1'b1, 1'b1}
  };

  int base;

  initial begin
    // Reset together with start resolves to reset.
    start = 1'b1;
    run(2);
    chk_en = 1'b1;
    check("reset fsm_state", 32'(fsm_state), 0);
    check("reset state", 32'(state), 0);
    check("reset cycle_count", 32'(cycle_count), 0);

    // Free run over a NOP stream.
    reset = 1'b0; enable = 1'b1; step_mode = 1'b0;
    wb_ir = ir(OP_NOP); mem_ir = ir(OP_NOP);
    tick();
    start = 1'b0;
    check("state after start", 32'(state), 1);
    run(10);
    check("nop run cycle_count", 32'(cycle_count), 10);
    check("nop run instr_count", 32'(instr_count), 0);

    // Branch resolution while running.
    mem_ir = ir(OP_BZ); zf = 1'b1;
    #1 check("bz zf=1 flush", 32'(flush), 1);
    zf = 1'b0;
    #1 check("bz zf=0 flush", 32'(flush), 0);
    wb_ir = ir(OP_ALU);
    for (int i = 0; i < 10; i++) begin
      mem_ir = ir(tab[i].op); zf = tab[i].z; nf = tab[i].n; cf = tab[i].c;
      tick();
    end

    // Pause and resume.
    enable = 1'b0;
    tick();
    check("pause fsm_state", 32'(fsm_state), M_PAUSE);
    mem_ir = ir(OP_JMPR);
    #1 check("jmpr idle flush", 32'(flush), 0);
    enable = 1'b1;
    tick();
    check("resume fsm_state", 32'(fsm_state), M_RUN);
    step_mode = 1'b1;
    tick();
    check("step_mode pause", 32'(fsm_state), M_PAUSE);

    // Held step gives one pulse; a second press gives another.
    base = m_cyc; hi_cnt = 0; win = 1'b1;
    step = 1'b1; run(5);
    step = 1'b0; run(2);
    step = 1'b1; run(3);
    step = 1'b0; tick();
    win = 1'b0;
    check("step pulse count", 32'(hi_cnt), 2);
    check("step cycle delta", 32'(cycle_count), base + 2);

    // Reset during a step_fire cycle.
    step = 1'b1;
    tick();
    check("step_fire state", 32'(state), 1);
    reset = 1'b1;
    tick();
    check("reset mid-step state", 32'(state), 0);
    check("reset mid-step fsm", 32'(fsm_state), M_IDLE);
    check("reset mid-step cyc", 32'(cycle_count), 0);
    check("reset mid-step ins", 32'(instr_count), 0);
    reset = 1'b0;
    tick();
    check("no residual pulse", 32'(state), 0);
    step = 1'b0;

    // HALT retiring in RUN, then sticky.
    step_mode = 1'b0; enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; wb_ir = ir(OP_ALU);
    run(3);
    wb_ir = ir(OP_HALT);
    tick();
    check("halt fsm_state", 32'(fsm_state), M_HALTED);
    check("halt halted", 32'(halted), 1);
    check("halt state", 32'(state), 0);
    check("halt cycle_count", 32'(cycle_count), 4);
    check("halt instr_count", 32'(instr_count), 4);
    wb_ir = ir(OP_NOP); start = 1'b1; step_mode = 1'b1; step = 1'b1;
    run(2);
    step = 1'b0; tick();
    step = 1'b1; tick();
    check("sticky fsm_state", 32'(fsm_state), M_HALTED);
    check("sticky cycle_count", 32'(cycle_count), 4);
    check("sticky instr_count", 32'(instr_count), 4);
    start = 1'b0; step = 1'b0;

    // HALT retiring on a single step.
    reset = 1'b1; tick();
    reset = 1'b0; start = 1'b1; step_mode = 1'b1;
    tick();
    start = 1'b0;
    check("step start fsm", 32'(fsm_state), M_PAUSE);
    wb_ir = ir(OP_HALT); step = 1'b1;
    tick();
    check("halt step state", 32'(state), 1);
    tick();
    check("step halt fsm", 32'(fsm_state), M_HALTED);
    check("step halt cyc", 32'(cycle_count), 1);
    check("step halt ins", 32'(instr_count), 1);
    step = 1'b0;

    // Counter saturation.
    reset = 1'b1; tick();
    reset = 1'b0; step_mode = 1'b0; enable = 1'b1; start = 1'b1; wb_ir = ir(OP_ALU);
    tick();
    start = 1'b0;
    run(65540);
    check("sat cycle_count", 32'(cycle_count), 32'h0000FFFF);
    check("sat instr_count", 32'(instr_count), 32'h0000FFFF);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 The block SHALL have the following ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  level; leaves IDLE.
- enable  in  1  run switch; 0 requests pause.
- step_mode  in  1  1 = single-step operation.
- step  in  1  step button level; the block edge-detects it internally.
- mem_ir  in  16  instruction in MEM stage.
- wb_ir  in  16  instruction in WB stage.
- zf, nf, cf  in  1 each  ALU flags aligned with mem_ir.
- state  out  1  1 = exec, 0 = idle; drives every pipeline stage.
- flush  out  1  squash ID/EX contents this cycle.
- halted  out  1  HALT retired.
- fsm_state  out  2  IDLE=00, RUN=01, PAUSE=10, HALTED=11.
- cycle_count  out  16  exec cycles elapsed.
- instr_count  out  16  non-NOP instructions retired.
REQ-002 Opcode is bits [15:11]; opcode values (HALT, NOP, BZ, BNZ, BN, BNN, BC, BNC, JMPR) SHALL come from the shared opcode definitions.

Function
REQ-003 In IDLE, start=1 SHALL move the FSM to RUN if step_mode=0, else to PAUSE.
REQ-004 In RUN, priority SHALL be: wb_ir HALT -> HALTED; else enable=0 or step_mode=1 -> PAUSE; else stay in RUN.
REQ-005 In PAUSE, enable=1 with step_mode=0 SHALL move the FSM to RUN on the next edge.
REQ-006 step_fire SHALL be a registered one-cycle pulse, set on the edge after step rises (step=1, step_d=0) while in PAUSE with step_mode=1.
- A held step SHALL produce exactly one pulse.
REQ-007 state SHALL equal (fsm_state==RUN) OR step_fire; it is combinational from registers only.
REQ-008 During a step_fire cycle, wb_ir HALT SHALL move the FSM to HALTED; otherwise the FSM stays in PAUSE.
REQ-009 HALTED SHALL be sticky until reset; start, enable and step are ignored; halted=1 exactly when fsm_state==HALTED.
REQ-010 flush SHALL be combinational and equal state AND taken, where taken is:
- BZ&zf, BNZ&!zf, BN&nf, BNN&!nf, BC&cf, BNC&!cf, or JMPR, all on mem_ir.
REQ-011 flush SHALL be 0 whenever state=0, regardless of mem_ir and flags.
REQ-012 cycle_count SHALL increment by 1 on each edge where state=1, saturating at 16'hFFFF.
REQ-013 instr_count SHALL increment on each edge where state=1 and wb_ir opcode != NOP, saturating at 16'hFFFF.
- The HALT instruction itself SHALL be counted.
REQ-014 Counters SHALL hold their value in PAUSE, IDLE and HALTED.
REQ-015 Simultaneous start and reset SHALL resolve to reset.

Reset
REQ-016 With reset=1 at an edge:
- fsm_state SHALL be IDLE, step_fire 0, step_d 0, cycle_count 0, instr_count 0.
- Outputs SHALL then be state=0, flush=0, halted=0.
REQ-017 Reset SHALL take effect from any state, including mid-step and HALTED, with no residual pulse on the following cycle.

Verification
REQ-018 Reset, start=1, step_mode=0, enable=1, NOP stream for 10 cycles -> state=1 from the cycle after start; cycle_count=10, instr_count=0.
REQ-019 RUN, wb_ir=HALT for one cycle -> next cycle fsm_state=11, halted=1, state=0; counters frozen; start=1 has no effect.
REQ-020 step_mode=1 in PAUSE; step held high 5 cycles, then low, then high again -> exactly two state=1 cycles total; cycle_count +2.
REQ-021 RUN, mem_ir=BZ with zf=1 -> flush=1 that cycle; BZ with zf=0 -> flush=0; JMPR with state=0 -> flush=0.
REQ-022 cycle_count preloaded near max by running 65540 exec cycles -> holds at 16'hFFFF.
REQ-023 reset asserted during a step_fire cycle -> next cycle state=0, fsm_state=00, all counters 0.
